// File: rtl/intt_pe_unswap_if.sv
// Handshake and data bundle for the INTT unswap delay commutator.
// The master drives the input pairs; the slave (the commutator) drives the regrouped pairs.
interface intt_pe_unswap_if #(
  parameter int unsigned COE_WIDTH      = 39,
  parameter int unsigned MAX_LOG_STRIDE = 6
);
  localparam int unsigned LsW = $clog2(MAX_LOG_STRIDE + 1);

  logic                 i_start;
  logic                 i_vld;
  logic                 i_last;
  logic [LsW-1:0]       i_log_stride;
  logic [COE_WIDTH-1:0] i_coe_a;
  logic [COE_WIDTH-1:0] i_coe_b;
  logic                 o_vld;
  logic [COE_WIDTH-1:0] o_coe_a;
  logic [COE_WIDTH-1:0] o_coe_b;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;

  modport master (
    output i_start, i_vld, i_last, i_log_stride, i_coe_a, i_coe_b,
    input  o_vld, o_coe_a, o_coe_b, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_vld, i_last, i_log_stride, i_coe_a, i_coe_b,
    output o_vld, o_coe_a, o_coe_b, o_busy, o_done, o_err
  );
endinterface

// File: rtl/intt_pe_unswap.sv
// Two-lane streaming delay commutator: regroups butterfly-order pairs at stride D = 2^log_stride,
// producing the 2x2 block transpose of DxD sub-blocks, with its own phase counter and frame FSM.
module intt_pe_unswap #(
  parameter int unsigned COE_WIDTH      = 39,
  parameter int unsigned MAX_LOG_STRIDE = 6,
  parameter int unsigned Q_TYPE         = 0
) (
  input logic              clk,
  input logic              rst_n,
  intt_pe_unswap_if.slave  bus
);
  localparam int unsigned LsW   = $clog2(MAX_LOG_STRIDE + 1);
  localparam int unsigned CntW  = MAX_LOG_STRIDE + 1;
  localparam int unsigned PtrW  = MAX_LOG_STRIDE;
  localparam int unsigned Depth = 2 ** MAX_LOG_STRIDE;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  logic unused_q_type;
  assign unused_q_type = ^Q_TYPE;

  state_e               state_q, state_d;
  logic [LsW-1:0]       log_q, log_d, log_new;
  logic [CntW-1:0]      cnt_q, cnt_d, drain_q, drain_d;
  logic [CntW-1:0]      stride, mask, phase;
  logic [PtrW-1:0]      wp_q, rp;
  logic                 primed_q, primed_d, err_q, err_d;
  logic                 vld_q, vld_d, done_q, done_d;
  logic                 start_acc, sel_hi, log_clamp;
  logic [COE_WIDTH-1:0] mem_a [Depth];
  logic [COE_WIDTH-1:0] mem_b [Depth];
  logic [COE_WIDTH-1:0] ad, bd, s_a, s_b, coe_a_q, coe_b_q;

  assign log_clamp = bus.i_log_stride > LsW'(MAX_LOG_STRIDE);
  assign log_new   = log_clamp ? LsW'(MAX_LOG_STRIDE) : bus.i_log_stride;
  assign stride    = CntW'(1) << log_q;
  assign mask      = stride | (stride - CntW'(1));
  assign start_acc = (state_q == StIdle) && bus.i_start && bus.i_vld;
  // The start beat is phase 0 of the first block regardless of the stale counter.
  assign phase     = start_acc ? '0 : cnt_q;
  assign sel_hi    = phase[log_q];

  // Both circular buffers read D entries behind the write pointer.
  assign rp  = wp_q - stride[PtrW-1:0];
  assign bd  = mem_b[rp];
  assign ad  = mem_a[rp];
  assign s_a = sel_hi ? bd : bus.i_coe_a;
  assign s_b = sel_hi ? bus.i_coe_a : bd;

  always_ff @(posedge clk) begin
    mem_a[wp_q] <= s_a;
    mem_b[wp_q] <= bus.i_coe_b;
  end

  always_comb begin
    state_d  = state_q;
    log_d    = log_q;
    cnt_d    = (phase + CntW'(1)) & mask;
    drain_d  = drain_q;
    primed_d = primed_q;
    err_d    = err_q;
    vld_d    = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_acc) begin
          log_d    = log_new;
          err_d    = log_clamp;
          primed_d = (log_new == '0);
          cnt_d    = CntW'(1);
          if (bus.i_last) begin
            err_d   = 1'b1;
            drain_d = CntW'(1) << log_new;
            state_d = StDrain;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        vld_d = primed_q;
        // Output starts once the first half-block of lane A has been buffered.
        if (phase == stride - CntW'(1)) primed_d = 1'b1;
        if (!bus.i_vld || bus.i_start) err_d = 1'b1;
        if (bus.i_vld && bus.i_last) begin
          state_d = StDrain;
          drain_d = stride;
          if (phase != mask) err_d = 1'b1;
        end
      end
      StDrain: begin
        vld_d   = 1'b1;
        drain_d = drain_q - CntW'(1);
        if (bus.i_start) err_d = 1'b1;
        if (drain_q == CntW'(1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      log_q    <= '0;
      cnt_q    <= '0;
      drain_q  <= '0;
      primed_q <= 1'b0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      wp_q     <= '0;
      coe_a_q  <= '0;
      coe_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      log_q    <= log_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      primed_q <= primed_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      wp_q     <= wp_q + PtrW'(1);
      coe_a_q  <= ad;
      coe_b_q  <= s_b;
    end
  end

  assign bus.o_vld   = vld_q;
  assign bus.o_coe_a = coe_a_q;
  assign bus.o_coe_b = coe_b_q;
  assign bus.o_busy  = (state_q != StIdle) || done_q;
  assign bus.o_done  = done_q;
  assign bus.o_err   = err_q;
endmodule

// File: doc/intt_pe_unswap.md
Name: intt_pe_unswap

Overview:
Streaming two-lane delay commutator for the INTT datapath. It consumes coefficient pairs in NTT butterfly order and emits pairs regrouped at a runtime stride D = 2^i_log_stride. The output order is the 2x2 block transpose of DxD sub-blocks. It sits between INTT butterfly stages and undoes the pairing produced by the forward-path swap stage. It contains its own phase counter, delay buffers and frame FSM, so no external mux select is needed.

Parameters:
COE_WIDTH, 39, coefficient bit width.
MAX_LOG_STRIDE, 6, largest supported log2 stride. Buffer depth is 2^MAX_LOG_STRIDE per lane.
Q_TYPE, 0, modulus type tag. Passed through only; no effect on logic.

Ports:
clk  input  1  clock; all logic on posedge.
rst_n  input  1  synchronous active-low reset.
i_start  input  1  marks the first beat of a frame; must coincide with i_vld.
i_vld  input  1  input pair valid.
i_last  input  1  marks the last beat of a frame; must coincide with i_vld.
i_log_stride  input  $clog2(MAX_LOG_STRIDE+1)  log2 of D; sampled on the i_start beat.
i_coe_a  input  COE_WIDTH  lane-A coefficient.
i_coe_b  input  COE_WIDTH  lane-B coefficient.
o_vld  output  1  output pair valid.
o_coe_a  output  COE_WIDTH  first coefficient of the regrouped pair.
o_coe_b  output  COE_WIDTH  second coefficient of the regrouped pair.
o_busy  output  1  high in RUN or DRAIN.
o_done  output  1  one-cycle pulse on the final output beat of a frame.
o_err  output  1  sticky protocol error flag; cleared by reset or by an accepted i_start.

Behaviour:
- Reset (rst_n=0 at posedge): the FSM goes to IDLE, counters clear, and o_vld, o_done, o_err, o_busy are 0. o_coe_a and o_coe_b are 0. Buffer contents are don't-care. Reset mid-frame abandons the frame and emits no further o_vld.
- Frame definition: N beats with i_vld held high continuously from i_start through i_last. N must be a multiple of 2D. D = 2^i_log_stride latched at start. An i_log_stride value above MAX_LOG_STRIDE sets o_err and is clamped to MAX_LOG_STRIDE.
- FSM states:
  - IDLE: i_start&i_vld -> RUN. Clear o_err; latch D; phase counter = 0. If i_start&i_last arrive together, treat as an error and go to DRAIN.
  - RUN: every cycle, shift both lanes and increment the phase counter mod 2D. On i_vld&i_last -> DRAIN and load the drain counter with D.
  - DRAIN: the datapath keeps advancing with don't-care input. The drain counter decrements each cycle. When it reaches 0 -> IDLE, coinciding with the o_done beat.
- Functional mapping: let the input beats of one 2D block be indexed j=0..2D-1, starting at block cycle c.
  - For k=0..D-1, output beat k is (a_k, a_(k+D)) and is presented at cycle c+D+1+k.
  - For k=0..D-1, output beat D+k is (b_k, b_(k+D)) and is presented at cycle c+2D+1+k.
- Latency and timing:
  - First-output latency is D+1 cycles, one of which is the output register.
  - o_vld is asserted for exactly N consecutive cycles per frame.
  - The last output appears at (cycle of i_last)+D+1, with o_done high on that cycle.
- Structure: lane B passes through a D-deep delay and then a 2:1 swap controlled by phase bit log2(D) of the counter. The post-swap lane A passes through another D-deep delay. The delays are implemented as circular buffers of depth 2^MAX_LOG_STRIDE with a read offset of D.
- D=1 case: reduces to a 1-cycle delay commutator with a total latency of 2.
- Protocol errors: each sets o_err and leaves the datapath running.
  - i_vld drops in RUN before i_last.
  - i_start arrives in RUN or DRAIN. This start is ignored; the current frame continues.
  - i_last arrives at a beat count that is not a multiple of 2D.
- Back-to-back frames: an i_start during DRAIN is an error. The next frame may start on the cycle after o_done.
- Arithmetic: none. Coefficients are moved without modification.

Test Plan:
- Reset check: rst_n low for 2 cycles, then high -> o_vld=0, o_busy=0, o_err=0, o_done=0.
- D=2, N=4: i_log_stride=1, inputs a=10..13, b=20..23 on cycles 0-3 -> o_vld on cycles 3-6 with pairs (10,12),(11,13),(20,22),(21,23); o_done on cycle 6; o_busy falls after cycle 6.
- D=1, N=8: i_log_stride=0, a=i, b=100+i on cycles 0-7 -> outputs on cycles 2-9 with pairs (0,1),(100,101),(2,3),(102,103),(4,5),(104,105),(6,7),(106,107).
- D=2^MAX_LOG_STRIDE=64, N=256 random data -> outputs match the scoreboard transpose model; first o_vld at cycle 65; o_done at cycle 255+65=320.
- Protocol errors: i_vld dropped at beat 3 of an N=8, D=2 frame -> o_err=1 and stays high; a following i_start clears it. Separately, i_start during DRAIN -> ignored, o_err=1, the original frame's o_done still occurs.
- Reset mid-frame: assert rst_n=0 at beat 5 of an N=16 frame -> the next cycle o_vld=0, o_busy=0. A new frame started afterwards produces correct outputs.
